// File: rtl/conv_job_scheduler.sv
`default_nettype none
// =============================================================================
// Module  : conv_job_scheduler
// Brief   : Walks a filters x rows x cols output job through the 3x3xC FP32
//           convolution core: fetch window, clear, issue, wait, emit result.
// Rev     : 1.0  initial release
// =============================================================================
module conv_job_scheduler #(
    parameter int DATA_WIDTH     = 32,
    parameter int DIM_W          = 8,
    parameter int FILT_W         = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CLR_CYCLES     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DIM_W-1:0]      cfg_rows,
    input  logic [DIM_W-1:0]      cfg_cols,
    input  logic [FILT_W-1:0]     cfg_filters,
    output logic                  win_req,
    input  logic                  win_ack,
    output logic [FILT_W-1:0]     win_filt,
    output logic [DIM_W-1:0]      win_row,
    output logic [DIM_W-1:0]      win_col,
    output logic                  core_clr,
    output logic                  core_valid_in,
    input  logic                  core_valid_out,
    input  logic [DATA_WIDTH-1:0] core_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout
);

    localparam int c_to_w  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_clr_w = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [c_to_w-1:0]  c_to_max  = c_to_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_clr_w-1:0] c_clr_max = c_clr_w'(CLR_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_CLEAR   = 4'd2,
        S_ISSUE   = 4'd3,
        S_WAIT    = 4'd4,
        S_EMIT    = 4'd5,
        S_ADVANCE = 4'd6,
        S_DONE    = 4'd7,
        S_ERROR   = 4'd8
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_start_job;
    logic                  w_cfg_zero;
    logic                  w_col_max;
    logic                  w_row_max;
    logic                  w_filt_max;
    logic                  w_last;
    logic [DIM_W-1:0]      r_rows;
    logic [DIM_W-1:0]      r_cols;
    logic [FILT_W-1:0]     r_filts;
    logic [DIM_W-1:0]      r_row;
    logic [DIM_W-1:0]      r_col;
    logic [FILT_W-1:0]     r_filt;
    logic [c_to_w-1:0]     r_to_cnt;
    logic [c_clr_w-1:0]    r_clr_cnt;
    logic                  r_win_req;
    logic                  r_core_clr;
    logic                  r_core_valid_in;
    logic                  r_res_valid;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic                  r_res_last;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err_timeout;

    assign w_cfg_zero = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_filters == '0);
    assign w_col_max  = (r_col  == r_cols  - DIM_W'(1));
    assign w_row_max  = (r_row  == r_rows  - DIM_W'(1));
    assign w_filt_max = (r_filt == r_filts - FILT_W'(1));
    assign w_last     = w_col_max && w_row_max && w_filt_max;

    always_comb begin
        w_next      = r_state;
        w_start_job = 1'b0;
        case (r_state)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    w_start_job = 1'b1;
                    w_next      = w_cfg_zero ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:   if (win_ack) w_next = S_CLEAR;
            S_CLEAR:   if (r_clr_cnt == c_clr_max) w_next = S_ISSUE;
            S_ISSUE:   w_next = S_WAIT;
            S_WAIT: begin
                // A result arriving on the final allowed cycle still wins.
                if (core_valid_out)            w_next = S_EMIT;
                else if (r_to_cnt == c_to_max) w_next = S_ERROR;
            end
            S_EMIT:    if (res_ready) w_next = S_ADVANCE;
            S_ADVANCE: w_next = w_last ? S_DONE : S_FETCH;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE) && (r_state != S_ERROR)) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_rows          <= '0;
            r_cols          <= '0;
            r_filts         <= '0;
            r_row           <= '0;
            r_col           <= '0;
            r_filt          <= '0;
            r_to_cnt        <= '0;
            r_clr_cnt       <= '0;
            r_win_req       <= 1'b0;
            r_core_clr      <= 1'b0;
            r_core_valid_in <= 1'b0;
            r_res_valid     <= 1'b0;
            r_res_data      <= '0;
            r_res_last      <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err_timeout   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_clr_cnt <= (r_state == S_CLEAR) ? r_clr_cnt + c_clr_w'(1) : '0;
            r_to_cnt  <= (r_state == S_WAIT)  ? r_to_cnt + c_to_w'(1)   : '0;

            if (w_start_job) begin
                r_rows  <= cfg_rows;
                r_cols  <= cfg_cols;
                r_filts <= cfg_filters;
                r_row   <= '0;
                r_col   <= '0;
                r_filt  <= '0;
            end else if (r_state == S_ADVANCE) begin
                // Column fastest, then row, then filter.
                if (w_col_max) begin
                    r_col <= '0;
                    if (w_row_max) begin
                        r_row  <= '0;
                        r_filt <= w_filt_max ? '0 : r_filt + FILT_W'(1);
                    end else begin
                        r_row <= r_row + DIM_W'(1);
                    end
                end else begin
                    r_col <= r_col + DIM_W'(1);
                end
            end

            if ((r_state == S_WAIT) && (w_next == S_EMIT)) begin
                r_res_data <= core_result;
            end

            if (w_start_job) begin
                r_err_timeout <= 1'b0;
            end else if (w_next == S_ERROR) begin
                r_err_timeout <= 1'b1;
            end

            // Outputs are decoded from the next state so they line up with it.
            r_win_req       <= (w_next == S_FETCH);
            r_core_clr      <= (w_next == S_CLEAR);
            r_core_valid_in <= (w_next == S_ISSUE);
            r_res_valid     <= (w_next == S_EMIT);
            r_res_last      <= (w_next == S_EMIT) && w_last;
            r_done          <= (w_next == S_DONE);
            r_busy          <= !(w_next inside {S_IDLE, S_ERROR, S_DONE});
        end
    end

    assign win_req       = r_win_req;
    assign win_filt      = r_filt;
    assign win_row       = r_row;
    assign win_col       = r_col;
    assign core_clr      = r_core_clr;
    assign core_valid_in = r_core_valid_in;
    assign res_valid     = r_res_valid;
    assign res_data      = r_res_data;
    assign res_last      = r_res_last;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err_timeout   = r_err_timeout;

endmodule
`default_nettype wire
